// File: rtl/sdcard_sector_buffer_if.sv
// Bus bundle between the SD card DMA stream, the sector buffer and its downstream reader.
// The master side drives DMA bytes and reader requests; the slave side is the buffer.
interface sdcard_sector_buffer_if;
    logic [7:0]  dma_data;
    logic [8:0]  dma_addr;
    logic        dma_strobe;
    logic [8:0]  rd_addr;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_bank_ready;
    logic        rd_done;
    logic [15:0] rd_checksum;

    modport master (
        output dma_data, dma_addr, dma_strobe, rd_addr, rd_en, rd_done,
        input  rd_data, rd_valid, rd_bank_ready, rd_checksum
    );

    modport slave (
        input  dma_data, dma_addr, dma_strobe, rd_addr, rd_en, rd_done,
        output rd_data, rd_valid, rd_bank_ready, rd_checksum
    );
endinterface

// File: rtl/sdcard_sector_buffer.sv
// Two-bank ping-pong buffer capturing whole 512-byte SD sectors from the DMA stream.
// Optional per-bank byte checksum is enabled by defining SDCARD_SECTOR_CHECKSUM_EN.
module sdcard_sector_buffer #(
    parameter int DROP_CNT_WIDTH  = 8,
    parameter int BANK_COUNT_LOG2 = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    sdcard_sector_buffer_if.slave     bus,
    output logic                      overflow,
    output logic                      seq_err,
    input  logic                      err_clr,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
    output logic                      wr_bank,
    output logic                      rd_bank
);

    localparam int BANKS = 2 ** BANK_COUNT_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DROP
    } wr_state_t;

    wr_state_t        state;
    logic [8:0]       exp_addr;
    logic [BANKS-1:0] full;
    logic [7:0]       mem [BANKS*512];

    logic at_start;
    logic at_last;
    logic in_seq;
    logic start_ok;
    logic start_drop;
    logic seq_fault;
    logic sector_done;
    logic release_rd;
    logic mem_we;

    // IDLE and DROP share the sector-start decision; FILL only accepts in-order bytes or a restart.
    assign at_start    = (bus.dma_addr == 9'd0);
    assign at_last     = (bus.dma_addr == 9'd511);
    assign in_seq      = (bus.dma_addr == exp_addr);
    assign start_ok    = bus.dma_strobe && (state != S_FILL) && at_start && !full[wr_bank];
    assign start_drop  = bus.dma_strobe && (state != S_FILL) && at_start && full[wr_bank];
    assign seq_fault   = bus.dma_strobe && (state == S_FILL) && !in_seq && !at_start;
    assign sector_done = bus.dma_strobe && (state == S_FILL) && in_seq && at_last;
    assign release_rd  = bus.rd_done && full[rd_bank];
    assign mem_we      = start_ok || (bus.dma_strobe && (state == S_FILL) && (in_seq || at_start));

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{wr_bank, bus.dma_addr}] <= bus.dma_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            exp_addr <= '0;
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            overflow <= 1'b0;
            seq_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (bus.dma_strobe) begin
                case (state)
                    S_FILL: begin
                        if (in_seq) begin
                            if (at_last) begin
                                state    <= S_IDLE;
                                exp_addr <= '0;
                            end else begin
                                exp_addr <= exp_addr + 9'd1;
                            end
                        end else if (at_start) begin
                            exp_addr <= 9'd1;
                        end else begin
                            state    <= S_IDLE;
                            exp_addr <= '0;
                        end
                    end
                    default: begin
                        if (start_ok) begin
                            state    <= S_FILL;
                            exp_addr <= 9'd1;
                        end else if (start_drop) begin
                            state <= S_DROP;
                        end else if ((state == S_DROP) && at_last) begin
                            state <= S_IDLE;
                        end
                    end
                endcase
            end

            // The filling bank is never full and the released bank always is, so these never collide.
            if (sector_done) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (release_rd) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end

            if (start_drop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (seq_fault) begin
                seq_err <= 1'b1;
            end else if (err_clr) begin
                seq_err <= 1'b0;
            end

            if (start_drop && (drop_cnt != {DROP_CNT_WIDTH{1'b1}})) begin
                drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= 8'h00;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.rd_data <= mem[{rd_bank, bus.rd_addr}];
            end
        end
    end

    assign bus.rd_bank_ready = full[rd_bank];

`ifdef SDCARD_SECTOR_CHECKSUM_EN
    logic [15:0] run_sum;
    logic [15:0] bank_sum [BANKS];

    // The latched value includes the final byte, which the running sum has not yet absorbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_sum <= '0;
            for (int i = 0; i < BANKS; i++) begin
                bank_sum[i] <= '0;
            end
        end else begin
            if (mem_we) begin
                if (at_start) begin
                    run_sum <= {8'h00, bus.dma_data};
                end else begin
                    run_sum <= run_sum + {8'h00, bus.dma_data};
                end
            end
            if (sector_done) begin
                bank_sum[wr_bank] <= run_sum + {8'h00, bus.dma_data};
            end
        end
    end

    assign bus.rd_checksum = bank_sum[rd_bank];
`else
    assign bus.rd_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_sdcard_sector_buffer.sv
// Directed scoreboard bench for sdcard_sector_buffer: read responses are queued and checked by a monitor.
// Status outputs are compared directly after each directed step.
module tb_sdcard_sector_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       err_clr;
    logic       overflow;
    logic       seq_err;
    logic [7:0] drop_cnt;
    logic       wr_bank;
    logic       rd_bank;

    int vectors     = 0;
    int miscompares = 0;

`ifdef SDCARD_SECTOR_CHECKSUM_EN
    localparam logic [15:0] FULL_SUM = 16'hFF00;
`else
    localparam logic [15:0] FULL_SUM = 16'h0000;
`endif

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_head;

    sdcard_sector_buffer_if bus();

    sdcard_sector_buffer #(
        .DROP_CNT_WIDTH (8),
        .BANK_COUNT_LOG2(1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .overflow(overflow),
        .seq_err (seq_err),
        .err_clr (err_clr),
        .drop_cnt(drop_cnt),
        .wr_bank (wr_bank),
        .rd_bank (rd_bank)
    );

    always #5 clk = ~clk;

    // Read-data monitor: every rd_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.rd_valid) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_rd_valid: got rd_data 0x%0h, expected no response", bus.rd_data);
            end else begin
                sb_head = sb_q.pop_front();
                if (bus.rd_data !== sb_head.val) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", sb_head.tag, bus.rd_data, sb_head.val);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] addr, input logic [7:0] data);
        bus.dma_addr   = addr;
        bus.dma_data   = data;
        bus.dma_strobe = 1'b1;
        tick();
        bus.dma_strobe = 1'b0;
    endtask

    task automatic streamRange(input int lo, input int hi, input logic [7:0] mask);
        for (int a = lo; a <= hi; a++) begin
            applyStimulus(9'(a), 8'(a) ^ mask);
        end
    endtask

    task automatic readByte(input logic [8:0] addr, input logic [7:0] exp, input string tag);
        sb_q.push_back('{tag: tag, val: exp});
        bus.rd_addr = addr;
        bus.rd_en   = 1'b1;
        tick();
        bus.rd_en   = 1'b0;
        tick();
    endtask

    task automatic releaseBank();
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
    endtask

    task automatic checkResetState(input string pfx);
        checkOutput({pfx, "_ready"},    32'(bus.rd_bank_ready), 32'd0);
        checkOutput({pfx, "_wr_bank"},  32'(wr_bank),           32'd0);
        checkOutput({pfx, "_rd_bank"},  32'(rd_bank),           32'd0);
        checkOutput({pfx, "_overflow"}, 32'(overflow),          32'd0);
        checkOutput({pfx, "_seq_err"},  32'(seq_err),           32'd0);
        checkOutput({pfx, "_drop_cnt"}, 32'(drop_cnt),          32'd0);
        checkOutput({pfx, "_rd_valid"}, 32'(bus.rd_valid),      32'd0);
        checkOutput({pfx, "_rd_data"},  32'(bus.rd_data),       32'd0);
        checkOutput({pfx, "_checksum"}, 32'(bus.rd_checksum),   32'd0);
    endtask

    initial begin
        bus.dma_data   = 8'h00;
        bus.dma_addr   = 9'd0;
        bus.dma_strobe = 1'b0;
        bus.rd_addr    = 9'd0;
        bus.rd_en      = 1'b0;
        bus.rd_done    = 1'b0;
        err_clr        = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        checkResetState("reset");
        rst = 1'b0;
        tick();

        // Single clean sector lands in bank 0.
        streamRange(0, 511, 8'h00);
        checkOutput("s1_ready",    32'(bus.rd_bank_ready), 32'd1);
        checkOutput("s1_wr_bank",  32'(wr_bank),           32'd1);
        checkOutput("s1_checksum", 32'(bus.rd_checksum),   32'(FULL_SUM));
        readByte(9'd5, 8'h05, "s1_read5");

        // Second sector fills bank 1, third is dropped.
        streamRange(0, 511, 8'hA5);
        checkOutput("s2_wr_bank", 32'(wr_bank), 32'd0);
        streamRange(0, 511, 8'h5A);
        checkOutput("s3_overflow", 32'(overflow), 32'd1);
        checkOutput("s3_drop_cnt", 32'(drop_cnt), 32'd1);
        checkOutput("s3_wr_bank",  32'(wr_bank),  32'd0);
        releaseBank();
        checkOutput("rel1_rd_bank", 32'(rd_bank),           32'd1);
        checkOutput("rel1_ready",   32'(bus.rd_bank_ready), 32'd1);
        readByte(9'd7, 8'hA2, "bank1_read7");
        streamRange(0, 511, 8'h3C);
        checkOutput("s4_wr_bank",  32'(wr_bank),  32'd1);
        checkOutput("s4_overflow", 32'(overflow), 32'd0 + 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("clr_overflow", 32'(overflow), 32'd0);
        checkOutput("clr_drop_cnt", 32'(drop_cnt), 32'd1);
        releaseBank();
        checkOutput("rel2_rd_bank", 32'(rd_bank), 32'd0);
        readByte(9'd9, 8'h35, "bank0_read9");
        releaseBank();
        checkOutput("rel3_rd_bank", 32'(rd_bank),           32'd1);
        checkOutput("rel3_ready",   32'(bus.rd_bank_ready), 32'd0);

        // Out-of-sequence address aborts the sector in bank 1.
        streamRange(0, 99, 8'h00);
        applyStimulus(9'd200, 8'hEE);
        checkOutput("seq_err_set",   32'(seq_err),           32'd1);
        checkOutput("seq_ready",     32'(bus.rd_bank_ready), 32'd0);
        checkOutput("seq_wr_bank",   32'(wr_bank),           32'd1);
        streamRange(0, 511, 8'h5A);
        checkOutput("seq_clean_ready", 32'(bus.rd_bank_ready), 32'd1);
        checkOutput("seq_clean_wrb",   32'(wr_bank),           32'd0);
        readByte(9'd100, 8'h3E, "seq_clean_read100");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("seq_err_clr", 32'(seq_err), 32'd0);
        releaseBank();
        checkOutput("seq_rel_rd_bank", 32'(rd_bank), 32'd0);

        // Mid-sector restart keeps the second pass and raises no fault.
        streamRange(0, 49, 8'hFF);
        streamRange(0, 511, 8'h11);
        checkOutput("rst_seq_err", 32'(seq_err),           32'd0);
        checkOutput("rst_ready",   32'(bus.rd_bank_ready), 32'd1);
        checkOutput("rst_wr_bank", 32'(wr_bank),           32'd1);
        readByte(9'd20, 8'h05, "restart_read20");
        readByte(9'd49, 8'h20, "restart_read49");

        // Release and a start strobe on the same edge: the bank is still full, so the sector drops.
        streamRange(0, 511, 8'h77);
        checkOutput("both_full_wrb", 32'(wr_bank), 32'd0);
        bus.rd_done = 1'b1;
        applyStimulus(9'd0, 8'h77);
        bus.rd_done = 1'b0;
        streamRange(1, 511, 8'h77);
        checkOutput("race_drop_cnt", 32'(drop_cnt),          32'd2);
        checkOutput("race_overflow", 32'(overflow),          32'd1);
        checkOutput("race_rd_bank",  32'(rd_bank),           32'd1);
        checkOutput("race_ready",    32'(bus.rd_bank_ready), 32'd1);
        checkOutput("race_wr_bank",  32'(wr_bank),           32'd0);
        readByte(9'd3, 8'h74, "race_read3");

        // Asynchronous reset in the middle of a fill.
        releaseBank();
        streamRange(0, 300, 8'h00);
        rst = 1'b1;
        #2;
        checkResetState("midfill");
        tick();
        tick();
        rst = 1'b0;
        tick();
        streamRange(0, 511, 8'h99);
        checkOutput("post_rst_wr_bank", 32'(wr_bank),           32'd1);
        checkOutput("post_rst_ready",   32'(bus.rd_bank_ready), 32'd1);
        checkOutput("post_rst_sum",     32'(bus.rd_checksum),   32'(FULL_SUM));
        readByte(9'd300, 8'hB5, "post_rst_read300");

        // Repeated dropped starts saturate the drop counter.
        streamRange(0, 511, 8'h00);
        for (int i = 0; i < 300; i++) begin
            applyStimulus(9'd0, 8'h00);
        end
        checkOutput("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
        checkOutput("sat_overflow", 32'(overflow), 32'd1);
        checkOutput("sat_rd_bank",  32'(rd_bank),  32'd0);

        tick();
        tick();
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
